// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: captures ALU results, maintains CPSR/sticky V, buffers writes to the register file.
// Latency: 1 cycle from accept to out_valid; CPSR/sticky_v change on the accepting edge.
// Backpressure: in_ready drops only when the FIFO is full and the head is not popping; compares always accepted.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         ALU result handshake (opcode, rd, r, N/Z/V/C, set_flags)
//   out_valid/out_ready       register-file write handshake (out_rd, out_data)
//   cpsr                      architectural flags {N,Z,C,V}
//   sticky_v, clr_sticky      sticky overflow and its synchronous clear
//   count                     result FIFO occupancy

// wb_fifo: generic circular buffer with registered storage and a combinational head read.
// Latency: a pushed word is visible at o_dat one cycle later (if the FIFO was empty).
// Backpressure: none internally; the caller must not push when full unless popping in the same cycle.
module wb_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [W-1:0]           i_dat,
   output logic [W-1:0]           o_dat,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   // Pointers are exactly AW bits wide, so DEPTH being a power of two
   // makes the natural overflow the modulo-DEPTH wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_dat;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (i_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_dat   = r_mem[r_rptr];
   assign o_count = r_count;
endmodule

module alu_writeback_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2,
   parameter int RD_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_opcode,
   input  logic [RD_W-1:0]        in_rd,
   input  logic [WIDTH-1:0]       in_r,
   input  logic                   in_negative,
   input  logic                   in_zero,
   input  logic                   in_overflow,
   input  logic                   in_cout,
   input  logic                   in_set_flags,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RD_W-1:0]        out_rd,
   output logic [WIDTH-1:0]       out_data,
   output logic [3:0]             cpsr,
   output logic                   sticky_v,
   input  logic                   clr_sticky,
   output logic [$clog2(DEPTH):0] count
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [4:0] OP_CMP = 5'b00101;

   typedef struct packed {
      logic [RD_W-1:0]  rd;
      logic [WIDTH-1:0] dat;
   } wb_ent_t;

   logic          w_is_cmp;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_out_vld;
   logic [CW-1:0] w_count;
   logic [3:0]    w_flags;
   logic [3:0]    w_class_mask;
   logic [3:0]    w_upd_mask;
   wb_ent_t       w_wr_ent;
   wb_ent_t       w_head;

   logic [3:0]    r_cpsr;
   logic          r_sticky;

   assign w_is_cmp  = (in_opcode == OP_CMP);
   assign w_out_vld = (w_count != '0);
   assign w_pop     = w_out_vld & out_ready;

   // Ready never depends on in_valid; a popping head frees a slot this cycle.
   assign in_ready  = w_is_cmp | (w_count < DEPTH_C) | w_pop;
   assign w_accept  = in_valid & in_ready;
   assign w_push    = w_accept & ~w_is_cmp;

   assign w_wr_ent  = '{rd: in_rd, dat: in_r};

   wb_fifo #(
      .W     ($bits(wb_ent_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_dat   (w_wr_ent),
      .o_dat   (w_head),
      .o_count (w_count)
   );

   // Flag vector in CPSR bit order {N,Z,C,V}.
   assign w_flags = {in_negative, in_zero, in_cout, in_overflow};

   // Which CPSR bits the presented opcode is allowed to load.
   always_comb begin
      w_class_mask = 4'b0000;
      if (w_is_cmp) begin
         w_class_mask = 4'b1111;
      end else if (in_set_flags) begin
         case (in_opcode) inside
            5'b00000, [5'b00110:5'b01100]:               w_class_mask = 4'b1100;
            [5'b11000:5'b11100]:                         w_class_mask = 4'b1110;
            [5'b00001:5'b00100], [5'b01111:5'b10011]:    w_class_mask = 4'b1111;
            default:                                     w_class_mask = 4'b0000;
         endcase
      end
   end

   assign w_upd_mask = w_accept ? w_class_mask : 4'b0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpsr   <= 4'b0000;
         r_sticky <= 1'b0;
      end else begin
         r_cpsr <= (r_cpsr & ~w_upd_mask) | (w_flags & w_upd_mask);
         // A V=1 load outranks a same-cycle clear.
         if (w_upd_mask[0] & in_overflow) begin
            r_sticky <= 1'b1;
         end else if (clr_sticky) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign out_valid = w_out_vld;
   assign out_rd    = w_head.rd;
   assign out_data  = w_head.dat;
   assign cpsr      = r_cpsr;
   assign sticky_v  = r_sticky;
   assign count     = w_count;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed scenarios plus randomized traffic against a queue-based reference.
// Latency: checks land 4 time units after each rising edge, inputs change 1 unit after it.
// Backpressure: out_ready is driven directly and randomly to exercise full/empty corners.
module tb_alu_writeback_stage;
   localparam int WIDTH = 16;
   localparam int DEPTH = 2;
   localparam int RD_W  = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_opcode;
   logic [RD_W-1:0]  in_rd;
   logic [WIDTH-1:0] in_r;
   logic             in_negative, in_zero, in_overflow, in_cout;
   logic             in_set_flags;
   logic             out_valid;
   logic             out_ready;
   logic [RD_W-1:0]  out_rd;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       cpsr;
   logic             sticky_v;
   logic             clr_sticky;
   logic [CW-1:0]    count;

   alu_writeback_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_rd        (in_rd),
      .in_r         (in_r),
      .in_negative  (in_negative),
      .in_zero      (in_zero),
      .in_overflow  (in_overflow),
      .in_cout      (in_cout),
      .in_set_flags (in_set_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rd       (out_rd),
      .out_data     (out_data),
      .cpsr         (cpsr),
      .sticky_v     (sticky_v),
      .clr_sticky   (clr_sticky),
      .count        (count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference: pending writes in order, plus architectural flags.
   typedef struct {
      logic [RD_W-1:0]  rd;
      logic [WIDTH-1:0] d;
   } ent_t;
   ent_t       mq[$];
   logic [3:0] m_cpsr;
   logic       m_sticky;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Bits of {N,Z,C,V} that an accepted opcode loads.
   function automatic logic [3:0] flag_mask(input logic [4:0] op, input logic sf);
      int o;
      o = int'(op);
      if (o == 5) return 4'b1111;
      if (!sf) return 4'b0000;
      if (o == 0 || (o >= 6 && o <= 12)) return 4'b1100;
      if (o >= 24 && o <= 28) return 4'b1110;
      if ((o >= 1 && o <= 4) || (o >= 15 && o <= 19)) return 4'b1111;
      return 4'b0000;
   endfunction

   task automatic drive(input logic v, input logic [4:0] op, input logic [RD_W-1:0] rd,
                        input logic [WIDTH-1:0] r, input logic [3:0] nzcv, input logic sf,
                        input logic ordy, input logic clr);
      in_valid     = v;
      in_opcode    = op;
      in_rd        = rd;
      in_r         = r;
      in_negative  = nzcv[3];
      in_zero      = nzcv[2];
      in_cout      = nzcv[1];
      in_overflow  = nzcv[0];
      in_set_flags = sf;
      out_ready    = ordy;
      clr_sticky   = clr;
   endtask

   // Called at posedge+1; checks before the next edge, updates the model on it, returns at posedge+1.
   task automatic step();
      bit         cmp, exp_rdy, pop, acc;
      logic [3:0] m;
      ent_t       e;
      #3;
      cmp     = (in_opcode == 5'b00101);
      pop     = (mq.size() != 0) && out_ready;
      exp_rdy = cmp || (mq.size() < DEPTH) || pop;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("count", 32'(count), mq.size());
      if (mq.size() != 0) begin
         check("out_rd", 32'(out_rd), 32'(mq[0].rd));
         check("out_data", 32'(out_data), 32'(mq[0].d));
      end
      check("cpsr", 32'(cpsr), 32'(m_cpsr));
      check("sticky_v", 32'(sticky_v), 32'(m_sticky));
      acc = in_valid && exp_rdy;
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (acc && !cmp) begin
         e.rd = in_rd;
         e.d  = in_r;
         mq.push_back(e);
      end
      m = acc ? flag_mask(in_opcode, in_set_flags) : 4'b0000;
      m_cpsr = (m_cpsr & ~m) | ({in_negative, in_zero, in_cout, in_overflow} & m);
      if (m[0] && in_overflow) m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_cpsr   = 4'b0000;
      m_sticky = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
      model_reset();
      #3;
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_rd", 32'(out_rd), 0);
      check("rst_cpsr", 32'(cpsr), 0);
      check("rst_sticky", 32'(sticky_v), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single add, drained immediately.
      drive(1'b1, 5'b00001, 4'd3, 16'h0005, 4'b0000, 1'b1, 1'b1, 1'b0);
      step();
      check("t1_count", 32'(count), 1);
      check("t1_out_rd", 32'(out_rd), 3);
      check("t1_out_data", 32'(out_data), 32'h5);
      check("t1_cpsr", 32'(cpsr), 0);
      in_valid = 1'b0;
      step();
      check("t1_count_after", 32'(count), 0);

      // Fill with out_ready=0, then push the third while draining.
      drive(1'b1, 5'b00001, 4'd1, 16'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
      step();
      in_r = 16'd2; in_rd = 4'd2;
      step();
      check("t2_full_count", 32'(count), 2);
      check("t2_head", 32'(out_data), 1);
      in_r = 16'd3; in_rd = 4'd4;
      step();                                   // in_ready must be 0 here
      out_ready = 1'b1;
      #1;
      check("t2_ready_on_pop", 32'(in_ready), 1);
      #(-0);
      step();
      in_valid = 1'b0;
      repeat (3) step();

      // CPSR partial updates: set C,V via compare, then logic op, then shift.
      drive(1'b1, 5'b00101, 4'd0, 16'd0, 4'b0011, 1'b0, 1'b1, 1'b0);
      step();
      check("t3_cmp", 32'(cpsr), 32'b0011);
      drive(1'b1, 5'b00110, 4'd5, 16'h00F0, 4'b1000, 1'b1, 1'b1, 1'b0);
      step();
      check("t3_logic", 32'(cpsr), 32'b1011);
      drive(1'b1, 5'b11001, 4'd6, 16'h0000, 4'b0100, 1'b1, 1'b1, 1'b0);
      step();
      check("t3_shift", 32'(cpsr), 32'b0101);

      // Compare while full; sticky clear afterwards.
      drive(1'b0, 5'd0, '0, '0, 4'b0000, 1'b0, 1'b1, 1'b1);
      repeat (2) step();
      check("t4_sticky_clr0", 32'(sticky_v), 0);
      drive(1'b1, 5'b00001, 4'd7, 16'h0011, 4'b0000, 1'b0, 1'b0, 1'b0);
      repeat (2) step();
      check("t4_full", 32'(count), 2);
      drive(1'b1, 5'b00101, 4'd0, 16'd0, 4'b1011, 1'b0, 1'b0, 1'b0);
      #1;
      check("t4_cmp_ready", 32'(in_ready), 1);
      step();
      check("t4_cpsr", 32'(cpsr), 32'b1011);
      check("t4_count", 32'(count), 2);
      check("t4_sticky", 32'(sticky_v), 1);
      drive(1'b0, 5'd0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      check("t4_sticky_cleared", 32'(sticky_v), 0);

      // Set beats clear in the same cycle.
      drive(1'b1, 5'b00001, 4'd8, 16'h7FFF, 4'b0001, 1'b1, 1'b1, 1'b1);
      step();
      check("t5_set_wins", 32'(sticky_v), 1);
      in_valid = 1'b0; clr_sticky = 1'b0;
      repeat (3) step();

      // Asynchronous reset mid-cycle with a full FIFO.
      drive(1'b1, 5'b00001, 4'd9, 16'h1234, 4'b1100, 1'b1, 1'b0, 1'b0);
      repeat (2) step();
      check("t6_pre_count", 32'(count), 2);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", 32'(out_valid), 0);
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_cpsr", 32'(cpsr), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(1'b1, 5'b00010, 4'd10, 16'hBEEF, 4'b0000, 1'b0, 1'b0, 1'b0);
      step();
      check("t6_post_rd", 32'(out_rd), 10);
      check("t6_post_data", 32'(out_data), 32'hBEEF);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] op;
         op = ($urandom_range(0, 5) == 0) ? 5'b00101 : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 3) != 0), op, RD_W'($urandom), WIDTH'($urandom),
               4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 7) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Sits directly downstream of the 16-bit combinational ALU.
- Captures each ALU result (r plus N/Z/V/C flags) with a valid/ready handshake and holds the architectural flag register (CPSR), updated in issue order per opcode class.
- Buffers results in a DEPTH-entry FIFO and drains them to the register-file write port through a second valid/ready handshake.
- Compare operations (opcode 5'b00101) update flags only and never enter the FIFO.

Parameters:
- WIDTH, 16, datapath width of ALU result and write data.
- DEPTH, 2, result FIFO entries; power of two, at least 2.
- RD_W, 4, destination register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result presented.
- in_ready  output  1  stage can accept this cycle.
- in_opcode  input  5  opcode of the operation that produced the result.
- in_rd  input  RD_W  destination register.
- in_r  input  WIDTH  ALU result r.
- in_negative, in_zero, in_overflow, in_cout  input  1 each  ALU flags.
- in_set_flags  input  1  instruction S-bit; enables CPSR update for non-compare ops.
- out_valid  output  1  head entry available.
- out_ready  input  1  register file accepts head entry.
- out_rd  output  RD_W  head destination.
- out_data  output  WIDTH  head result.
- cpsr  output  4  {N,Z,C,V}.
- sticky_v  output  1  sticky overflow, set by any CPSR V update to 1.
- clr_sticky  input  1  synchronous clear of sticky_v.
- count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): count=0, FIFO pointers=0, out_valid=0, out_data=0, out_rd=0, cpsr=4'b0000, sticky_v=0. All storage returns to reset mid-transfer; in-flight entries are discarded.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready:
  - Compare (in_opcode==5'b00101): 1 regardless of occupancy, because no FIFO entry is used.
  - Otherwise: (count<DEPTH) | pop. A same-cycle pop frees a slot, so a full FIFO with out_ready=1 accepts.
  - in_ready is combinational from in_opcode, count and out_ready; there is no path from in_valid.
- Push: accept and opcode!=00101 -> write {in_rd,in_r} at the write pointer. The pointer wraps modulo DEPTH.
- Output: out_valid = (count!=0). out_data/out_rd are driven from the head entry, registered storage only, with no input-to-output bypass. Latency from accept to out_valid is 1 cycle.
- count' = count + push - pop. Simultaneous push and pop leaves count unchanged, including at count==DEPTH and count==0 (at count==0 the pop is impossible since out_valid=0).
- out_data/out_rd hold stable while out_valid=1 and out_ready=0.
- CPSR update on accept only, applied at the clock edge; the new value is visible the cycle after:
  - 00101 compare: N,Z,C,V all loaded, regardless of in_set_flags.
  - in_set_flags=0 (non-compare): no change.
  - 00000 (mov), 00110..01100 (and/or/nor/nand/xor/xnor/not): N,Z loaded; C,V kept.
  - 11000..11100 (shifts): N,Z,C loaded; V kept.
  - 00001, 00010 (add/sub), 00011, 00100, 01111, 10000 (mul), 10001..10011 (fp): N,Z,C,V loaded.
  - Any other opcode: accepted and pushed, CPSR unchanged.
- sticky_v: set when a CPSR update loads V=1. Otherwise clr_sticky=1 clears it. Set wins when both occur in the same cycle.
- Flag order equals accept order; FIFO drain stalls never delay CPSR updates.

Test Plan:
- Reset, then in_valid=1, opcode=00001, rd=3, r=16'h0005, set_flags=1, flags N0 Z0 C0 V0, out_ready=1 -> next cycle out_valid=1, out_rd=3, out_data=16'h0005, cpsr=4'b0000, count=1; following cycle count=0.
- out_ready=0, push three adds (r=1,2,3) -> in_ready=0 after the 2nd accept, count=2, out_data=1. Raise out_ready with the 3rd still valid -> accepted same cycle; outputs 1,2,3 in order.
- cpsr=4'b0011 (C=1,V=1), accept opcode 00110 set_flags=1 with N1 Z0 C0 V0 -> cpsr=4'b1011. Then shift 11001 with N0 Z1 C0 -> cpsr=4'b0101.
- FIFO full with out_ready=0, opcode=00101 with flags N1 Z0 C1 V1, set_flags=0 -> in_ready=1, cpsr=4'b1011, count stays 2, sticky_v=1. Next cycle clr_sticky=1 -> sticky_v=0.
- Add with V=1 accepted in the same cycle as clr_sticky=1 -> sticky_v=1.
- Assert rst asynchronously mid-cycle with count=2 -> out_valid=0, count=0 and cpsr=0 immediately, before any clock edge. After release, the first accepted result appears with rd/data intact.
